i2s_sound_tx: RTL and testbench
===============================

Name: i2s_sound_tx

Overview:
- I2S master transmitter; mirror of the I2S sample receiver path.
- Buffers stereo 16-bit sample pairs written by the system side in a FIFO.
- Generates bit clock and word-select from the system clock and serializes samples MSB-first in Philips I2S format to the external DAC/audio chip.
- On underrun it transmits silence and reports the event.

Parameters:
- FIFOPOINTERWIDTH, 5, log2 of FIFO depth; depth = 32 stereo pairs.
- CLKDIV, 4, system clocks per bit-clock half period; must be ≥ 1; bit-clock period = 2*CLKDIV system clocks.

Ports:
- IwClk  input  1  system clock; all logic on rising edge.
- IwReset  input  1  asynchronous, active-high reset.
- IwEnable  input  1  run request for the serializer.
- IwSampleWrite  input  1  push strobe; one pair per cycle when high and OwSampleReady high.
- IbSampleLeft  input  16  left sample, two's complement.
- IbSampleRight  input  16  right sample, two's complement.
- OwSampleReady  output  1  FIFO not full.
- ObFIFOLevel  output  FIFOPOINTERWIDTH+1  number of stored pairs.
- OwUnderrun  output  1  one-cycle pulse when a frame load finds the FIFO empty.
- OwI2SClk  output  1  bit clock.
- OwI2SLRClk  output  1  word select; 0 = left, 1 = right.
- OwI2SData  output  1  serial data.

Behaviour:
Reset:
- All outputs registered.
- On IwReset: OwI2SClk, OwI2SLRClk, OwI2SData, OwUnderrun = 0; ObFIFOLevel = 0; OwSampleReady = 1.
- FIFO pointers, divider, slot counter (0) and shift register (0) are cleared; state = IDLE.
- Reset mid-frame aborts immediately; FIFO contents are discarded.

FIFO:
- Depth 2^FIFOPOINTERWIDTH entries of {left,right}; pointers wrap modulo depth.
- Level counter with full flag at level = depth. OwSampleReady = !full, registered from the level.
- A write while full is ignored; level and data are unchanged.
- Pop occurs only at frame load.
- Push and pop in the same cycle: both take effect and the level is unchanged, including when full.

State machine:
- IDLE:
  - OwI2SClk = 0, OwI2SLRClk = 0, OwI2SData = 0; divider held at 0.
  - IwEnable = 1 -> RUN with slot = 0.
- RUN:
  - Divider counts 0..CLKDIV-1; at CLKDIV-1 it wraps and OwI2SClk toggles.
  - Rising edge of OwI2SClk: no data action.
  - Falling edge: slot advances (31 wraps to 0), and these updates occur in the same IwClk cycle as the toggle:
    - OwI2SLRClk <= 1 if new slot ≥ 16, else 0.
    - New slot = 1: load the shift register with {left,right} from the FIFO head and pop. If the FIFO is empty, load 32'h0 and pulse OwUnderrun.
    - Any other slot: shift the register left by one, filling with 0.
  - OwI2SData = shift register bit 31.
  - Result: the left MSB appears one bit clock after OwI2SLRClk falls, and the right MSB appears one bit clock after it rises (slot 17). Slot 0 carries the previous frame's right LSB.
  - A frame is 32 bit clocks = 64*CLKDIV system clocks.
  - Leave RUN only at the falling edge that enters slot 1 with IwEnable = 0: no load, no pop, then go to IDLE. Slot 0 (right LSB) has then been fully sent. Deassertion mid-frame completes the current frame.
- The first frame after IDLE starts at slot 0, with data 0 on that slot.

Test Plan:
- CLKDIV=2; reset; push one pair L=16'hA5C3, R=16'h0F01; IwEnable=1 -> OwI2SClk period 4 clocks; OwI2SLRClk low slots 0-15; data on slots 1..16 = A5C3 MSB-first; slots 17..31 plus next slot 0 = 0F01; ObFIFOLevel 1 -> 0 at first load.
- Empty FIFO at second frame load -> OwUnderrun high exactly 1 clock; slots 1..31 and next slot 0 data all 0; OwI2SClk and OwI2SLRClk keep running.
- Push 33 pairs with the serializer idle (depth 32) -> OwSampleReady falls after 32nd write; 33rd ignored; ObFIFOLevel = 32; transmitted order matches write order, confirming pointer wrap.
- FIFO full, IwSampleWrite held high across a load -> level stays 32; new pair accepted; no data lost or duplicated.
- Drop IwEnable at slot 8 -> frame finishes through slot 0 with correct right sample; IDLE with OwI2SClk = 0; no extra pop (level unchanged).
- Assert IwReset at slot 20 with level 5 -> all outputs 0 asynchronously; ObFIFOLevel = 0; OwSampleReady = 1; after release with IwEnable = 1, framing restarts at slot 0.

Source files
------------

// File: rtl/i2s_sound_tx.sv
// I2S master transmitter: stereo 16-bit pairs are queued in a FIFO and sent
// MSB-first in Philips format with bit clock and word select derived from IwClk.
module i2s_sound_tx #(
    parameter int FIFOPOINTERWIDTH = 5,
    parameter int CLKDIV = 4
) (
    input  logic                        IwClk,
    input  logic                        IwReset,
    input  logic                        IwEnable,
    input  logic                        IwSampleWrite,
    input  logic [15:0]                 IbSampleLeft,
    input  logic [15:0]                 IbSampleRight,
    output logic                        OwSampleReady,
    output logic [FIFOPOINTERWIDTH:0]   ObFIFOLevel,
    output logic                        OwUnderrun,
    output logic                        OwI2SClk,
    output logic                        OwI2SLRClk,
    output logic                        OwI2SData
);
    localparam int DEPTH = 1 << FIFOPOINTERWIDTH;
    localparam int DIVWIDTH = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [FIFOPOINTERWIDTH:0] FULLLEVEL = (FIFOPOINTERWIDTH + 1)'(DEPTH);
    localparam logic [DIVWIDTH-1:0] DIVLAST = DIVWIDTH'(CLKDIV - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateType;

    stateType state, nextState;

    logic [31:0]                 fifoMem [DEPTH];
    logic [FIFOPOINTERWIDTH-1:0] writePtr, readPtr;
    logic [FIFOPOINTERWIDTH:0]   level, nextLevel;
    logic                        sampleReady;
    logic                        fifoEmpty, fifoFull, push, pop;

    logic [DIVWIDTH-1:0]         divider;
    logic [4:0]                  slot, nextSlot;
    logic [31:0]                 shiftReg;
    logic                        bitClk, lrClk, underrun;
    logic                        divWrap, fallEdge, frameLoad, frameExit;

    always_ff @(posedge IwClk or posedge IwReset) begin
        if (IwReset) state <= IDLE;
        else         state <= nextState;
    end

    // Frame boundary is the falling bit-clock edge that enters slot 1.
    always_comb begin
        nextState = state;
        divWrap   = 1'b0;
        fallEdge  = 1'b0;
        frameLoad = 1'b0;
        frameExit = 1'b0;
        nextSlot  = slot + 5'd1;
        case (state)
            IDLE: begin
                if (IwEnable) nextState = RUN;
            end
            RUN: begin
                divWrap  = (divider == DIVLAST);
                fallEdge = divWrap && bitClk;
                if (fallEdge && (nextSlot == 5'd1)) begin
                    if (IwEnable) begin
                        frameLoad = 1'b1;
                    end else begin
                        frameExit = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
        endcase
    end

    assign fifoEmpty = (level == '0);
    assign fifoFull  = (level == FULLLEVEL);
    assign pop       = frameLoad && !fifoEmpty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push      = IwSampleWrite && (!fifoFull || pop);

    always_comb begin
        nextLevel = level;
        if (push && !pop)      nextLevel = level + 1'b1;
        else if (pop && !push) nextLevel = level - 1'b1;
    end

    always_ff @(posedge IwClk) begin
        if (push) fifoMem[writePtr] <= {IbSampleLeft, IbSampleRight};
    end

    always_ff @(posedge IwClk or posedge IwReset) begin
        if (IwReset) begin
            writePtr    <= '0;
            readPtr     <= '0;
            level       <= '0;
            sampleReady <= 1'b1;
        end else begin
            if (push) writePtr <= writePtr + 1'b1;
            if (pop)  readPtr  <= readPtr + 1'b1;
            level       <= nextLevel;
            sampleReady <= (nextLevel != FULLLEVEL);
        end
    end

    always_ff @(posedge IwClk or posedge IwReset) begin
        if (IwReset) begin
            divider  <= '0;
            bitClk   <= 1'b0;
            lrClk    <= 1'b0;
            slot     <= '0;
            shiftReg <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if ((state == IDLE) || frameExit) begin
                divider  <= '0;
                bitClk   <= 1'b0;
                lrClk    <= 1'b0;
                slot     <= '0;
                shiftReg <= '0;
            end else begin
                divider <= divWrap ? '0 : divider + 1'b1;
                if (divWrap) bitClk <= !bitClk;
                if (fallEdge) begin
                    slot  <= nextSlot;
                    lrClk <= nextSlot[4];
                    if (frameLoad) begin
                        shiftReg <= pop ? fifoMem[readPtr] : '0;
                        underrun <= !pop;
                    end else begin
                        shiftReg <= {shiftReg[30:0], 1'b0};
                    end
                end
            end
        end
    end

    assign OwSampleReady = sampleReady;
    assign ObFIFOLevel   = level;
    assign OwUnderrun    = underrun;
    assign OwI2SClk      = bitClk;
    assign OwI2SLRClk    = lrClk;
    assign OwI2SData     = shiftReg[31];
endmodule

// File: tb/tb_i2s_sound_tx.sv
// Bench for i2s_sound_tx: directed tables for the framing and FIFO corners plus
// randomized traffic checked every cycle against a frame-level reference model.
module tb_i2s_sound_tx;
    localparam int FPW = 5;
    localparam int CLKDIV = 2;
    localparam int DEPTH = 1 << FPW;
    localparam int FRAME = 64 * CLKDIV;

    typedef struct {
        logic expLr;
        logic expData;
    } slotVecType;

    typedef struct {
        logic [15:0]  left;
        logic [15:0]  right;
        logic         expReady;
        logic [FPW:0] expLevel;
    } fillVecType;

    logic         IwClk = 1'b0;
    logic         IwReset = 1'b0;
    logic         IwEnable = 1'b0;
    logic         IwSampleWrite = 1'b0;
    logic [15:0]  IbSampleLeft = '0;
    logic [15:0]  IbSampleRight = '0;
    logic         OwSampleReady, OwUnderrun, OwI2SClk, OwI2SLRClk, OwI2SData;
    logic [FPW:0] ObFIFOLevel;

    int vecCount = 0;
    int missCount = 0;

    slotVecType slotTbl [33];
    fillVecType fillTbl [33];

    i2s_sound_tx #(.FIFOPOINTERWIDTH(FPW), .CLKDIV(CLKDIV)) dut (
        .IwClk(IwClk),
        .IwReset(IwReset),
        .IwEnable(IwEnable),
        .IwSampleWrite(IwSampleWrite),
        .IbSampleLeft(IbSampleLeft),
        .IbSampleRight(IbSampleRight),
        .OwSampleReady(OwSampleReady),
        .ObFIFOLevel(ObFIFOLevel),
        .OwUnderrun(OwUnderrun),
        .OwI2SClk(OwI2SClk),
        .OwI2SLRClk(OwI2SLRClk),
        .OwI2SData(OwI2SData)
    );

    always #5 IwClk = ~IwClk;

    // Reference model: a queue of pairs, a time-in-run counter and the frame being sent.
    logic [31:0] exp_q[$];
    logic        mRun = 1'b0;
    int          mT = 0;
    logic [31:0] mFrame = '0;
    logic        mUnder = 1'b0;
    int          mLoads = 0;

    always @(posedge IwClk or posedge IwReset) begin
        if (IwReset) begin
            exp_q.delete();
            mRun   <= 1'b0;
            mT     <= 0;
            mFrame <= '0;
            mUnder <= 1'b0;
        end else begin
            mUnder <= 1'b0;
            if (!mRun) begin
                if (IwEnable) begin
                    mRun   <= 1'b1;
                    mT     <= 0;
                    mFrame <= '0;
                end
            end else if (((mT + 1) % FRAME) == 2 * CLKDIV) begin
                mT <= 2 * CLKDIV;
                if (!IwEnable) begin
                    mRun   <= 1'b0;
                    mT     <= 0;
                    mFrame <= '0;
                end else if (exp_q.size() > 0) begin
                    mFrame <= exp_q.pop_front();
                    mLoads <= mLoads + 1;
                end else begin
                    mFrame <= '0;
                    mUnder <= 1'b1;
                    mLoads <= mLoads + 1;
                end
            end else begin
                mT <= (mT + 1) % FRAME;
            end
            if (IwSampleWrite && (exp_q.size() < DEPTH)) exp_q.push_back({IbSampleLeft, IbSampleRight});
        end
    end

    function automatic logic [FPW+5:0] expOutputs();
        int   slotNow;
        logic bclk, lr, data;
        slotNow = (mT / (2 * CLKDIV)) % 32;
        bclk = mRun && (((mT / CLKDIV) % 2) == 1);
        lr   = mRun && (slotNow >= 16);
        data = mRun && mFrame[(32 - slotNow) % 32];
        return {bclk, lr, data, mUnder, exp_q.size() < DEPTH, (FPW + 1)'(exp_q.size())};
    endfunction

    always @(negedge IwClk) begin : cycleChecker
        logic [FPW+5:0] actV, expV;
        actV = {OwI2SClk, OwI2SLRClk, OwI2SData, OwUnderrun, OwSampleReady, ObFIFOLevel};
        expV = expOutputs();
        vecCount++;
        if (actV !== expV) begin
            missCount++;
            $display("FAIL cycle_model t=%0t clk/lr/data/under/ready/level got %b required %b", $time, actV, expV);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vecCount++;
        if (act !== expv) begin
            missCount++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic pushPair(input logic [31:0] p);
        IbSampleLeft  = p[31:16];
        IbSampleRight = p[15:0];
        IwSampleWrite = 1'b1;
        @(negedge IwClk);
        IwSampleWrite = 1'b0;
    endtask

    task automatic waitBitRise(output int cyc, output bit ok);
        logic prev;
        ok = 1'b0;
        @(negedge IwClk);
        prev = OwI2SClk;
        cyc = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge IwClk);
            cyc++;
            if (OwI2SClk && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = OwI2SClk;
        end
    endtask

    task automatic waitSlot(input int slotWanted, input int minLoads, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 * FRAME; i++) begin
            @(negedge IwClk);
            if (mRun && (mLoads >= minLoads) && ((mT / (2 * CLKDIV)) == slotWanted)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0]  pairL, pairR;
        logic [31:0]  newPair;
        logic [FPW:0] savedLevel;
        logic         prevClk, prevLr;
        int           cyc, under, rises, lrRises, pct;
        bit           ok;

        pairL = 16'hA5C3;
        pairR = 16'h0F01;
        for (int k = 0; k <= 32; k++) begin
            slotTbl[k].expLr = ((k % 32) >= 16);
            if (k == 0)       slotTbl[k].expData = 1'b0;
            else if (k <= 16) slotTbl[k].expData = pairL[16 - k];
            else              slotTbl[k].expData = pairR[32 - k];
        end
        for (int i = 0; i < 33; i++) begin
            fillTbl[i].left     = 16'($urandom);
            fillTbl[i].right    = 16'($urandom);
            fillTbl[i].expReady = ((i + 1) < DEPTH);
            fillTbl[i].expLevel = (FPW + 1)'(((i + 1) < DEPTH) ? (i + 1) : DEPTH);
        end

        #1 IwReset = 1'b1;
        repeat (3) @(negedge IwClk);
        check("reset_outputs", {OwI2SClk, OwI2SLRClk, OwI2SData, OwUnderrun}, 4'b0000);
        check("reset_ready", OwSampleReady, 1);
        check("reset_level", ObFIFOLevel, 0);
        IwReset = 1'b0;
        @(negedge IwClk);

        // One pair, serialized slot by slot
        pushPair({pairL, pairR});
        check("level_after_push", ObFIFOLevel, 1);
        IwEnable = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            waitBitRise(cyc, ok);
            check($sformatf("slot%0d_bitclk_seen", k), ok, 1);
            if (k > 0) check($sformatf("slot%0d_bitclk_period", k), cyc, 2 * CLKDIV);
            check($sformatf("slot%0d_lr", k), OwI2SLRClk, slotTbl[k].expLr);
            check($sformatf("slot%0d_data", k), OwI2SData, slotTbl[k].expData);
            if (k == 1) check("level_after_load", ObFIFOLevel, 0);
        end

        // Second frame finds the FIFO empty
        under = 0;
        rises = 0;
        lrRises = 0;
        prevClk = OwI2SClk;
        prevLr = OwI2SLRClk;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge IwClk);
            if (OwUnderrun) under++;
            if (OwI2SClk && !prevClk) rises++;
            if (OwI2SLRClk && !prevLr) lrRises++;
            prevClk = OwI2SClk;
            prevLr = OwI2SLRClk;
        end
        check("underrun_pulse_cycles", under, 1);
        check("bitclk_rises_in_underrun_frame", rises, 32);
        check("lr_rises_in_underrun_frame", lrRises, 1);
        IwEnable = 1'b0;
        repeat (2 * FRAME) @(negedge IwClk);
        check("idle_bitclk", OwI2SClk, 0);

        // Fill past depth with the serializer idle
        for (int i = 0; i < 33; i++) begin
            IbSampleLeft  = fillTbl[i].left;
            IbSampleRight = fillTbl[i].right;
            IwSampleWrite = 1'b1;
            @(negedge IwClk);
            check($sformatf("fill%0d_ready", i), OwSampleReady, fillTbl[i].expReady);
            check($sformatf("fill%0d_level", i), ObFIFOLevel, fillTbl[i].expLevel);
        end

        // Write held high while full across the first load
        newPair = $urandom;
        IbSampleLeft  = newPair[31:16];
        IbSampleRight = newPair[15:0];
        IwEnable = 1'b1;
        repeat (12) @(negedge IwClk);
        check("full_level_across_load", ObFIFOLevel, DEPTH);
        check("full_ready_across_load", OwSampleReady, 0);
        IwSampleWrite = 1'b0;

        // Enable dropped at slot 8 of the third frame
        waitSlot(8, mLoads + 2, ok);
        check("reached_slot8", ok, 1);
        IwEnable = 1'b0;
        savedLevel = (FPW + 1)'(exp_q.size());
        rises = 0;
        prevClk = OwI2SClk;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge IwClk);
            if (OwI2SClk && !prevClk) rises++;
            prevClk = OwI2SClk;
        end
        check("rises_after_drop", rises, 25);
        check("drop_idle_outputs", {OwI2SClk, OwI2SLRClk, OwI2SData}, 3'b000);
        check("drop_level_unchanged", ObFIFOLevel, savedLevel);

        IwEnable = 1'b1;
        repeat (32 * FRAME) @(negedge IwClk);
        check("drained_level", ObFIFOLevel, 0);
        IwEnable = 1'b0;
        repeat (2 * FRAME) @(negedge IwClk);

        // Reset at slot 20 with five pairs stored
        for (int i = 0; i < 6; i++) pushPair($urandom);
        check("six_pushed_level", ObFIFOLevel, 6);
        IwEnable = 1'b1;
        waitSlot(20, mLoads + 1, ok);
        check("reached_slot20", ok, 1);
        check("level_at_slot20", ObFIFOLevel, 5);
        #1 IwReset = 1'b1;
        #1;
        check("async_reset_outputs", {OwI2SClk, OwI2SLRClk, OwI2SData, OwUnderrun}, 4'b0000);
        check("async_reset_level", ObFIFOLevel, 0);
        check("async_reset_ready", OwSampleReady, 1);
        repeat (2) @(negedge IwClk);
        IwReset = 1'b0;
        waitBitRise(cyc, ok);
        check("restart_bitclk_seen", ok, 1);
        check("restart_slot0_lr", OwI2SLRClk, 0);
        check("restart_slot0_data", OwI2SData, 0);

        // Randomized traffic, alternating sparse and dense writes
        for (int phase = 0; phase < 6; phase++) begin
            pct = (phase % 2 == 1) ? 60 : 1;
            for (int c = 0; c < 1500; c++) begin
                IwSampleWrite = ($urandom_range(0, 99) < pct);
                IbSampleLeft  = 16'($urandom);
                IbSampleRight = 16'($urandom);
                if ($urandom_range(0, 399) == 0) IwEnable = ~IwEnable;
                if ($urandom_range(0, 2999) == 0) begin
                    IwReset = 1'b1;
                    @(negedge IwClk);
                    IwReset = 1'b0;
                end
                @(negedge IwClk);
            end
        end
        IwSampleWrite = 1'b0;
        repeat (4) @(negedge IwClk);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
